// File: rtl/uart_frame_pkg.sv
// Shared frame constants, FSM encoding and checksum helper for the backplane UART link.
package uart_frame_pkg;

  localparam logic [7:0] HDR0_DEF      = 8'h55;
  localparam logic [7:0] HDR1_DEF      = 8'hAA;
  localparam int         FRAME_LEN     = 12;
  localparam int         BITS_PER_BYTE = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } tx_state_e;

  // Modulo-256 sum of the GA byte and the eight payload bytes.
  function automatic logic [7:0] frame_chk(input logic [4:0] ga, input logic [63:0] data);
    logic [7:0] sum;
    sum = {3'b000, ga};
    for (int i = 0; i < 8; i++) begin
      sum = sum + data[8*i +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx_byte
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       I_clk_10M,
  input  logic       I_rst,
  input  logic       I_start,
  input  logic [7:0] I_byte,
  output logic       O_txb,
  output logic       O_done
);

  localparam int             BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
  localparam logic [3:0]     LAST_BIT  = 4'(BITS_PER_BYTE - 1);

  logic          active_r;
  logic [3:0]    bit_cnt_r;
  logic [BW-1:0] baud_r;
  logic [9:0]    shift_r;
  logic          txb_r;
  logic          bit_end_s;

  assign bit_end_s = active_r && (baud_r == BAUD_LAST);
  // Done covers the final cycle of the stop bit so the framer can restart with a 2-cycle gap.
  assign O_done    = bit_end_s && (bit_cnt_r == LAST_BIT);
  assign O_txb     = txb_r;

  // Bit sequencing: shift_r[0] is the bit currently on the line.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      active_r  <= 1'b0;
      bit_cnt_r <= 4'd0;
      baud_r    <= '0;
      shift_r   <= 10'h3FF;
      txb_r     <= 1'b1;
    end else if (!active_r) begin
      if (I_start) begin
        active_r  <= 1'b1;
        bit_cnt_r <= 4'd0;
        baud_r    <= '0;
        shift_r   <= {1'b1, I_byte, 1'b0};
        txb_r     <= 1'b0;
      end
    end else if (bit_end_s) begin
      baud_r <= '0;
      if (bit_cnt_r == LAST_BIT) begin
        active_r  <= 1'b0;
        bit_cnt_r <= 4'd0;
        txb_r     <= 1'b1;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        shift_r   <= {1'b1, shift_r[9:1]};
        txb_r     <= shift_r[1];
      end
    end else begin
      baud_r <= baud_r + BAUD_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_data.sv
// Transmit framer: latches a 64-bit word plus GA and sends HDR0 HDR1 GA D7..D0 CHK over 8N1.
module uart_tx_data
  import uart_frame_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] HDR0         = HDR0_DEF,
  parameter logic [7:0] HDR1         = HDR1_DEF
) (
  input  logic        I_clk_10M,
  input  logic        I_rst,
  input  logic [63:0] I_data,
  input  logic        I_data_vld,
  output logic        O_data_rdy,
  input  logic [4:0]  I_GA,
  output logic        O_txb,
  output logic        O_busy,
  output logic        O_frame_done
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  tx_state_e   state_r, state_nxt;
  logic [63:0] data_r;
  logic [4:0]  ga_r;
  logic [7:0]  chk_r;
  logic [3:0]  byte_idx_r;
  logic [7:0]  byte_r;
  logic [7:0]  byte_sel_s;
  logic        rdy_r, busy_r, frame_done_r;
  logic        accept_s, byte_start_s, byte_done_s;

  assign accept_s     = (state_r == ST_IDLE) && I_data_vld;
  assign O_data_rdy   = rdy_r;
  assign O_busy       = busy_r;
  assign O_frame_done = frame_done_r;

  // Next-state and byte-start decode.
  always_comb begin
    state_nxt    = state_r;
    byte_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt = ST_LOAD;
        else          state_nxt = ST_IDLE;
      end
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: begin
        byte_start_s = 1'b1;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!byte_done_s)               state_nxt = ST_WAIT;
        else if (byte_idx_r < LAST_IDX) state_nxt = ST_LOAD;
        else                            state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state_r      <= ST_IDLE;
      rdy_r        <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      rdy_r        <= (state_nxt == ST_IDLE);
      busy_r       <= (state_nxt != ST_IDLE);
      frame_done_r <= (state_nxt == ST_DONE);
    end
  end

  // Frame byte mux, indexed by position on the wire.
  always_comb begin
    byte_sel_s = 8'h00;
    case (byte_idx_r)
      4'd0:    byte_sel_s = HDR0;
      4'd1:    byte_sel_s = HDR1;
      4'd2:    byte_sel_s = {3'b000, ga_r};
      4'd3:    byte_sel_s = data_r[63:56];
      4'd4:    byte_sel_s = data_r[55:48];
      4'd5:    byte_sel_s = data_r[47:40];
      4'd6:    byte_sel_s = data_r[39:32];
      4'd7:    byte_sel_s = data_r[31:24];
      4'd8:    byte_sel_s = data_r[23:16];
      4'd9:    byte_sel_s = data_r[15:8];
      4'd10:   byte_sel_s = data_r[7:0];
      4'd11:   byte_sel_s = chk_r;
      default: byte_sel_s = 8'h00;
    endcase
  end

  // Payload capture, byte staging and byte index advance.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      data_r     <= 64'd0;
      ga_r       <= 5'd0;
      chk_r      <= 8'd0;
      byte_idx_r <= 4'd0;
      byte_r     <= 8'd0;
    end else if (accept_s) begin
      data_r     <= I_data;
      ga_r       <= I_GA;
      chk_r      <= frame_chk(I_GA, I_data);
      byte_idx_r <= 4'd0;
    end else if (state_r == ST_LOAD) begin
      byte_r <= byte_sel_s;
    end else if ((state_r == ST_WAIT) && byte_done_s && (byte_idx_r < LAST_IDX)) begin
      byte_idx_r <= byte_idx_r + 4'd1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .I_clk_10M (I_clk_10M),
    .I_rst     (I_rst),
    .I_start   (byte_start_s),
    .I_byte    (byte_r),
    .O_txb     (O_txb),
    .O_done    (byte_done_s)
  );

endmodule

// File: tb/tb_uart_tx_data.sv
// Self-checking bench: a UART RX model decodes the wire and compares against a frame scoreboard.
module tb_uart_tx_data;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [63:0] data = 64'd0;
  logic [4:0]  ga = 5'd0;
  logic        rdy, txb, busy, fdone;

  uart_tx_data #(.CLKS_PER_BIT(CPB)) dut (
    .I_clk_10M    (clk),
    .I_rst        (rst),
    .I_data       (data),
    .I_data_vld   (vld),
    .O_data_rdy   (rdy),
    .I_GA         (ga),
    .O_txb        (txb),
    .O_busy       (busy),
    .O_frame_done (fdone)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_b, last_rx;
  logic [9:0] rx_bits;
  logic       cur_bit;
  int         accept_cyc = 0, prev_start = 0, last_fd_cyc = 0, fd_count = 0, frame_pos = 0, rx_cnt = 0;
  bit         rx_act = 1'b0, hold_err = 1'b0, b2b_mode = 1'b0, fd_pend = 1'b0;

  task automatic push_frame(input logic [63:0] d, input logic [4:0] g);
    logic [7:0] sum;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back({3'b000, g});
    sum = {3'b000, g};
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(d[8*i +: 8]);
      sum = sum + d[8*i +: 8];
    end
    exp_q.push_back(sum);
  endtask

  // Accept detection, UART RX model and frame_done timing, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rx_act    = 1'b0;
      fd_pend   = 1'b0;
      frame_pos = 0;
      exp_q.delete();
    end else begin
      if (vld && rdy) begin
        if (b2b_mode) check_eq("b2b_accept", cyc + 1, last_fd_cyc + 2);
        push_frame(data, ga);
        accept_cyc = cyc + 1;
      end
      if (!rx_act) begin
        if (txb === 1'b0) begin
          rx_act   = 1'b1;
          rx_cnt   = 1;
          cur_bit  = 1'b0;
          rx_bits  = 10'd0;
          hold_err = 1'b0;
          if (frame_pos == 0) check_eq("hdr0_latency", cyc, accept_cyc + 2);
          else                check_eq("byte_gap", cyc, prev_start + BYTE_CYC + 2);
          prev_start = cyc;
        end
      end else begin
        if (rx_cnt % CPB == 0) begin
          cur_bit = txb;
          rx_bits[rx_cnt / CPB] = txb;
        end else if (txb !== cur_bit) begin
          hold_err = 1'b1;
        end
        rx_cnt++;
        if (rx_cnt == BYTE_CYC) begin
          rx_act = 1'b0;
          check_eq("bit_hold", hold_err, 1'b0);
          check_eq("stop_bit", rx_bits[9], 1'b1);
          check_eq("rx_q_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check_eq($sformatf("byte%0d", frame_pos), rx_bits[8:1], exp_b);
          end
          last_rx   = rx_bits[8:1];
          frame_pos = (frame_pos + 1) % 12;
        end
      end
      if (fdone) begin
        fd_count++;
        last_fd_cyc = cyc;
        fd_pend     = 1'b1;
        check_eq("done_time", cyc, prev_start + BYTE_CYC);
        check_eq("done_pos", frame_pos, 0);
        check_eq("busy_in_done", busy, 1'b1);
        check_eq("rdy_in_done", rdy, 1'b0);
      end else if (fd_pend) begin
        fd_pend = 1'b0;
        check_eq("rdy_after_done", rdy, 1'b1);
        check_eq("busy_after_done", busy, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (fd_count < n && t < budget) begin
      tick();
      t++;
    end
    check_eq("frame_timeout", fd_count >= n, 1'b1);
  endtask

  task automatic send(input logic [63:0] d, input logic [4:0] g);
    int t = 0;
    while (!rdy && t < 2000) begin
      tick();
      t++;
    end
    check_eq("rdy_timeout", rdy, 1'b1);
    data = d;
    ga   = g;
    vld  = 1'b1;
    tick();
    vld  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int  t;
    int  base;
    bit  bad_txb, bad_busy;

    // Reset held with a valid word waiting: no accept until reset is released.
    rst  = 1'b1;
    vld  = 1'b1;
    data = 64'h0102030405060708;
    ga   = 5'h03;
    repeat (3) tick();
    check_eq("rst_txb", txb, 1'b1);
    check_eq("rst_rdy", rdy, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fdone", fdone, 1'b0);
    rst = 1'b0;
    tick();
    vld = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("rdy_after_accept", rdy, 1'b0);
    wait_frames(1, 1000);
    repeat (5) tick();
    check_eq("fd_count_t1", fd_count, 1);
    check_eq("chk_sum", last_rx, 8'h27);

    // Checksum wrap-around.
    send(64'hFFFFFFFFFFFFFFFF, 5'h1F);
    wait_frames(2, 1000);
    check_eq("chk_wrap", last_rx, 8'h17);

    // Valid held high with data changing every cycle.
    vld  = 1'b1;
    data = 64'hA5A5_5A5A_C3C3_3C3C;
    ga   = 5'h05;
    tick();
    b2b_mode = 1'b1;
    t = 0;
    while (fd_count < 4 && t < 2000) begin
      data = {$urandom, $urandom};
      ga   = 5'($urandom);
      tick();
      t++;
    end
    vld      = 1'b0;
    b2b_mode = 1'b0;
    check_eq("b2b_frames", fd_count >= 4, 1'b1);
    repeat (5) tick();

    // Reset in the middle of byte 5, then a clean frame.
    send(64'h1122334455667788, 5'h0A);
    t = 0;
    while (!(rx_act && frame_pos == 5) && t < 1000) begin
      tick();
      t++;
    end
    check_eq("reach_byte5", rx_act && frame_pos == 5, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("midrst_txb", txb, 1'b1);
    check_eq("midrst_rdy", rdy, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    rst  = 1'b0;
    base = fd_count;
    send(64'hDEADBEEF01234567, 5'h11);
    wait_frames(base + 1, 1000);
    repeat (5) tick();
    check_eq("fd_count_t5", fd_count, base + 1);
    check_eq("chk_after_rst", last_rx, 8'h19);

    // Idle line with no valid.
    bad_txb  = 1'b0;
    bad_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (txb !== 1'b1) bad_txb = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check_eq("idle_txb", bad_txb, 1'b0);
    check_eq("idle_busy", bad_busy, 1'b0);
    check_eq("q_empty", exp_q.size(), 0);
    check_eq("fd_count_idle", fd_count, base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
